key_reverse_scheduler: RTL and testbench
========================================

KEY_REVERSE_SCHEDULER -- requirements
Module: key_reverse_scheduler

Interface
REQ-001 Parameter nk, default 4: key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 Parameter nb, default 4: state columns; fixed at 4.
REQ-003 Parameter nr, default 10: round count; 10, 12 and 14 pair with nk 4, 6 and 8.
REQ-004 Derived constant N = nb*(nr+1) is the total schedule words (44, 52 or 60).
REQ-005 clk  input  1: single clock; all state updates on rising edge.
REQ-006 rst  input  1: asynchronous, active-high reset.
REQ-007 start  input  1: one-cycle request to begin reverse generation; sampled in IDLE only.
REQ-008 last_key  input  32*nk: final nk schedule words packed {w[N-1],...,w[N-nk]}, with w[N-nk] in bits [31:0].
REQ-009 out_valid  output  1: out_word/out_index are valid.
REQ-010 out_ready  input  1: consumer accepts the current word.
REQ-011 out_word  output  32: schedule word w[out_index]; byte order matches forward expansion (rcon in bits [31:24]).
REQ-012 out_index  output  6: index of out_word, N-1 down to 0.
REQ-013 busy  output  1: high from accepted start until the final handshake.
REQ-014 done  output  1: one-cycle pulse the cycle after the index-0 handshake.

Function
REQ-015 Words SHALL be emitted strictly in descending index order, N-1 first and 0 last, one word per handshake.
REQ-016 A handshake SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-017 FSM states: IDLE, RUN, FIN; IDLE->RUN on start; RUN->FIN on handshake at index 0; FIN->IDLE unconditionally (done=1 in FIN).
REQ-018 On start in IDLE, last_key SHALL load into an nk-word window, with top = w[N-1], and the index counter SHALL load N-1.
REQ-019 out_valid SHALL rise the cycle after start (latency 1) and remain high in RUN.
REQ-020 out_word SHALL equal the window top, and out_index SHALL equal the counter i.
REQ-021 While out_valid=1 and out_ready=0, out_word and out_index SHALL hold stable.
REQ-022 On a handshake at index i>=nk, the block SHALL compute w[i-nk] = w[i] XOR g(w[i-1],i), shift the window down one word, insert w[i-nk] at the bottom, and decrement i.
REQ-023 g(x,i) for i mod nk = 0 SHALL be SubWord(RotWord(x)) XOR {rcon(i/nk),24'h0}.
REQ-024 RotWord SHALL be {x[23:0],x[31:24]}.
REQ-025 rcon(1..10) SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-026 g(x,i) for nk=8 and i mod nk = 4 SHALL be SubWord(x).
REQ-027 g(x,i) SHALL be x in all other cases.
REQ-028 On a handshake at index i<nk, the block SHALL shift the window only, with no computation and the bottom filled with zero.
REQ-029 With out_ready held high, throughput SHALL be one word per cycle, N cycles total.
REQ-030 start SHALL be ignored while busy=1 or in FIN.
REQ-031 last_key SHALL be sampled only at accepted start; later changes SHALL have no effect on the run.

Reset
REQ-032 rst SHALL force IDLE, window=0, i=0, out_valid=0, out_word=0, out_index=0, busy=0 and done=0, immediately and independent of clk.
REQ-033 Reset mid-run SHALL abort with no further output, and the first start after reset release SHALL run normally.

Structure
REQ-034 A shared package SHALL hold the S-box table, the rcon table, the state enum, and the N/width constants used by both schedule directions.
REQ-035 One sub-module, aes_sbox (8-bit forward S-box lookup), SHALL be instantiated four times for SubWord.
REQ-036 No other hierarchy SHALL be used.

Verification
REQ-037 AES-128: last_key = {b6630ca6, e13f0cc8, c9ee2589, d014f9a8} with out_ready=1 -> out_index 43..0 over 44 cycles, w[4]=a0fafe17, w[0]=2b7e1516, then done pulse.
REQ-038 AES-192 (nk=6, nr=12): last six words from the FIPS-197 vector -> first out_word 01002202 at index 51, last out_word 8e73b0f7 at index 0.
REQ-039 AES-256 (nk=8, nr=14): FIPS-197 last eight words -> index 59 = 706c631e, index 0 = 603deb10; the i mod 8 = 4 path is exercised.
REQ-040 Backpressure: out_ready=0 for 3 cycles at index 20 -> out_word/out_index constant, no skipped or duplicated index.
REQ-041 rst asserted asynchronously at index 30 -> out_valid=0, busy=0 without a clock edge; a new start then yields index 43 first.
REQ-042 start pulsed at index 10 during a run -> ignored, sequence unchanged, single done pulse.

Source files
------------

// File: rtl/key_reverse_scheduler_pkg.sv
// Shared AES key-schedule definitions: S-box, rcon, FSM states and sizing helpers.
// Used by both the forward and the reverse schedule blocks.
package key_reverse_scheduler_pkg;

   localparam int word_w = 32;
   localparam int idx_w  = 6;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   localparam logic [7:0] sbox_tbl [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic int sched_words(input int nb_p, input int nr_p);
      return nb_p * (nr_p + 1);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

endpackage

// File: rtl/key_reverse_scheduler_if.sv
// Start/key request and word-stream handshake for the reverse key scheduler.
interface key_reverse_scheduler_if #(parameter int nk = 4) ();
   logic              start;
   logic [32*nk-1:0]  last_key;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_word;
   logic [5:0]        out_index;
   logic              busy;
   logic              done;

   modport master (input start, last_key, out_ready,
                   output out_valid, out_word, out_index, busy, done);
   modport slave  (output start, last_key, out_ready,
                   input out_valid, out_word, out_index, busy, done);
endinterface

// File: rtl/aes_sbox.sv
// Single-byte forward AES S-box lookup.
module aes_sbox
   import key_reverse_scheduler_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);
   assign dout = sbox_tbl[din];
endmodule

// File: rtl/key_reverse_scheduler.sv
// Walks the AES key schedule backwards from its last nk words, emitting
// w[N-1] down to w[0] over a valid/ready stream, one word per handshake.
module key_reverse_scheduler
   import key_reverse_scheduler_pkg::*;
#(
   parameter int nk = 4,
   parameter int nb = 4,
   parameter int nr = 10
) (
   input  logic clk,
   input  logic rst,
   key_reverse_scheduler_if.master kif
);
   localparam int         n        = sched_words(nb, nr);
   localparam logic [5:0] last_idx = 6'(n - 1);
   localparam logic [5:0] nk_idx   = 6'(nk);

   state_t                state;
   logic [nk-1:0][31:0]   win;     // win[nk-1] = w[idx], win[0] = w[idx-nk+1]
   logic [5:0]            idx;
   logic [5:0]            phase;
   logic [3:0]            rnd;
   logic [31:0]           prev, sub_in, sub_out, g_word, next_word;
   logic                  hs;

   assign hs    = kif.out_valid & kif.out_ready;
   assign prev  = win[nk-2];
   assign phase = idx % nk_idx;
   assign rnd   = 4'(idx / nk_idx);

   assign sub_in = (phase == 6'd0) ? rot_word(prev) : prev;

   for (genvar b = 0; b < 4; b++) begin : g_sub
      aes_sbox u_sbox (.din(sub_in[8*b +: 8]), .dout(sub_out[8*b +: 8]));
   end

   always_comb begin
      g_word = prev;
      if (phase == 6'd0)
         g_word = sub_out ^ {rcon(rnd), 24'h0};
      else if (nk == 8 && phase == 6'd4)
         g_word = sub_out;
   end

   // Below index nk the remaining words are already in the window; fill with zero.
   assign next_word = (idx >= nk_idx) ? (win[nk-1] ^ g_word) : 32'h0;

   assign kif.out_word  = win[nk-1];
   assign kif.out_index = idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         win           <= '0;
         idx           <= '0;
         kif.out_valid <= 1'b0;
         kif.busy      <= 1'b0;
         kif.done      <= 1'b0;
      end else begin
         kif.done <= 1'b0;
         case (state)
            IDLE: if (kif.start) begin
               win           <= kif.last_key;
               idx           <= last_idx;
               kif.out_valid <= 1'b1;
               kif.busy      <= 1'b1;
               state         <= RUN;
            end
            RUN: if (hs) begin
               win <= {win[nk-2:0], next_word};
               if (idx == 6'd0) begin
                  kif.out_valid <= 1'b0;
                  kif.busy      <= 1'b0;
                  kif.done      <= 1'b1;
                  state         <= FIN;
               end else begin
                  idx <= idx - 6'd1;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_reverse_scheduler.sv
// Bench for key_reverse_scheduler: nk=4/6/8 instances checked against a
// forward key-expansion model with a GF(2^8)-derived S-box.
module tb_key_reverse_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int           sel = 4;
   logic         start_in = 1'b0, ready_in = 1'b1;
   logic [255:0] key_in = '0;

   key_reverse_scheduler_if #(.nk(4)) if4 ();
   key_reverse_scheduler_if #(.nk(6)) if6 ();
   key_reverse_scheduler_if #(.nk(8)) if8 ();

   key_reverse_scheduler #(.nk(4), .nb(4), .nr(10)) dut4 (.clk(clk), .rst(rst), .kif(if4.master));
   key_reverse_scheduler #(.nk(6), .nb(4), .nr(12)) dut6 (.clk(clk), .rst(rst), .kif(if6.master));
   key_reverse_scheduler #(.nk(8), .nb(4), .nr(14)) dut8 (.clk(clk), .rst(rst), .kif(if8.master));

   assign if4.start = start_in && sel == 4;
   assign if6.start = start_in && sel == 6;
   assign if8.start = start_in && sel == 8;
   assign if4.last_key = key_in[127:0];
   assign if6.last_key = key_in[191:0];
   assign if8.last_key = key_in;
   assign if4.out_ready = ready_in;
   assign if6.out_ready = ready_in;
   assign if8.out_ready = ready_in;

   logic        v_valid, v_busy, v_done;
   logic [31:0] v_word;
   logic [5:0]  v_index;
   always_comb begin
      v_valid = if4.out_valid; v_busy = if4.busy; v_done = if4.done;
      v_word = if4.out_word; v_index = if4.out_index;
      if (sel == 6) begin
         v_valid = if6.out_valid; v_busy = if6.busy; v_done = if6.done;
         v_word = if6.out_word; v_index = if6.out_index;
      end else if (sel == 8) begin
         v_valid = if8.out_valid; v_busy = if8.busy; v_done = if8.done;
         v_word = if8.out_word; v_index = if8.out_index;
      end
   end

   int errors = 0, checks = 0;
   logic [7:0]  sb [256];
   logic [31:0] mw [60];
   logic [31:0] cap_word [$];
   logic [5:0]  cap_idx [$];
   int cap_done, hold_bad, busy_bad, first_valid, valid_cycles;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00, aa = a, bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
      return (b << s) | (b >> (8 - s));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h01;
         for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
   endfunction

   function automatic int n_of(input int k);
      return 4 * (k + 7);
   endfunction

   // Forward FIPS-197 expansion from mw[0..k-1].
   task automatic expand(input int k);
      logic [7:0] rc = 8'h01;
      for (int i = k; i < n_of(k); i++) begin
         logic [31:0] t = mw[i-1];
         if (i % k == 0) begin
            t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (k > 6 && i % k == 4) begin
            t = subw(t);
         end
         mw[i] = mw[i-k] ^ t;
      end
   endtask

   function automatic logic [255:0] pack_last(input int k);
      logic [255:0] r = '0;
      for (int j = 0; j < k; j++) r[32*j +: 32] = mw[n_of(k) - k + j];
      return r;
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic rand_key(input int k);
      for (int j = 0; j < k; j++) mw[j] = $urandom();
      expand(k);
   endtask

   // Drives one run and records every handshake; comparisons are left to the tests.
   task automatic run_collect(input int k, input logic [255:0] key, input int stall_idx,
                              input int stall_len, input int restart_idx);
      int stalled = 0, post = -1, cyc = 0;
      bit pulsed = 0;
      logic [31:0] hw = '0;
      logic [5:0]  hi = '0;
      cap_word.delete(); cap_idx.delete();
      cap_done = 0; hold_bad = 0; busy_bad = 0; first_valid = -1; valid_cycles = 0;
      sel = k; ready_in = 1'b1;
      @(negedge clk); key_in = key; start_in = 1'b1;
      @(negedge clk); start_in = 1'b0; key_in = rnd256();
      while (cyc < 300 && post != 0) begin
         start_in = 1'b0;
         if (v_done) cap_done++;
         if (v_valid && first_valid < 0) first_valid = cyc;
         if (v_valid) begin
            valid_cycles++;
            if (!v_busy) busy_bad++;
         end
         if (v_valid && int'(v_index) == stall_idx && stalled < stall_len) begin
            if (stalled > 0 && (v_word !== hw || v_index !== hi)) hold_bad++;
            hw = v_word; hi = v_index; stalled++;
            ready_in = 1'b0;
         end else begin
            if (stalled > 0 && int'(v_index) == stall_idx && v_word !== hw) hold_bad++;
            ready_in = 1'b1;
         end
         if (v_valid && int'(v_index) == restart_idx && !pulsed) begin
            start_in = 1'b1; pulsed = 1; key_in = rnd256();
         end
         if (v_valid && ready_in) begin
            cap_word.push_back(v_word);
            cap_idx.push_back(v_index);
         end
         if (post > 0) post--;
         else if (post < 0 && v_done) post = 3;
         cyc++;
         @(negedge clk);
      end
      start_in = 1'b0; ready_in = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", v_valid); end
      checks++; if (v_word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 0", v_word); end
      checks++; if (v_index !== 6'h0) begin errors++; $display("FAIL reset_index: got %0d want 0", v_index); end
      checks++; if (v_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", v_busy); end
      checks++; if (v_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", v_done); end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_aes128();
      int bad = 0;
      mw[0] = 32'h2b7e1516; mw[1] = 32'h28aed2a6; mw[2] = 32'habf71588; mw[3] = 32'h09cf4f3c;
      expand(4);
      run_collect(4, {128'h0, 32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8}, -1, 0, -1);
      checks++; if (cap_word.size() != 44) begin errors++; $display("FAIL aes128_count: got %0d want 44", cap_word.size()); end
      for (int j = 0; j < cap_word.size() && j < 44; j++)
         if (cap_idx[j] !== 6'(43 - j) || cap_word[j] !== mw[43 - j]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL aes128_seq: got %0d bad words want 0", bad); end
      if (cap_word.size() == 44) begin
         checks++; if (cap_word[39] !== 32'ha0fafe17) begin errors++; $display("FAIL aes128_w4: got %h want a0fafe17", cap_word[39]); end
         checks++; if (cap_word[43] !== 32'h2b7e1516) begin errors++; $display("FAIL aes128_w0: got %h want 2b7e1516", cap_word[43]); end
      end
      checks++; if (first_valid != 0) begin errors++; $display("FAIL aes128_latency: got %0d want 0", first_valid); end
      checks++; if (valid_cycles != 44) begin errors++; $display("FAIL aes128_cycles: got %0d want 44", valid_cycles); end
      checks++; if (cap_done != 1) begin errors++; $display("FAIL aes128_done: got %0d want 1", cap_done); end
      checks++; if (busy_bad != 0) begin errors++; $display("FAIL aes128_busy: got %0d want 0", busy_bad); end
      checks++; if (v_busy !== 1'b0 || v_valid !== 1'b0) begin errors++; $display("FAIL aes128_idle: got busy=%b valid=%b want 0", v_busy, v_valid); end
   endtask

   task automatic test_aes192();
      int bad = 0;
      mw[0] = 32'h8e73b0f7; mw[1] = 32'hda0e6452; mw[2] = 32'hc810f32b;
      mw[3] = 32'h809079e5; mw[4] = 32'h62f8ead2; mw[5] = 32'h522c6b7b;
      expand(6);
      run_collect(6, pack_last(6), -1, 0, -1);
      checks++; if (cap_word.size() != 52) begin errors++; $display("FAIL aes192_count: got %0d want 52", cap_word.size()); end
      for (int j = 0; j < cap_word.size() && j < 52; j++)
         if (cap_idx[j] !== 6'(51 - j) || cap_word[j] !== mw[51 - j]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL aes192_seq: got %0d bad words want 0", bad); end
      if (cap_word.size() == 52) begin
         checks++; if (cap_word[0] !== 32'h01002202) begin errors++; $display("FAIL aes192_first: got %h want 01002202", cap_word[0]); end
         checks++; if (cap_word[51] !== 32'h8e73b0f7) begin errors++; $display("FAIL aes192_last: got %h want 8e73b0f7", cap_word[51]); end
      end
      checks++; if (cap_done != 1) begin errors++; $display("FAIL aes192_done: got %0d want 1", cap_done); end
   endtask

   task automatic test_aes256();
      int bad = 0;
      mw[0] = 32'h603deb10; mw[1] = 32'h15ca71be; mw[2] = 32'h2b73aef0; mw[3] = 32'h857d7781;
      mw[4] = 32'h1f352c07; mw[5] = 32'h3b6108d7; mw[6] = 32'h2d9810a3; mw[7] = 32'h0914dff4;
      expand(8);
      run_collect(8, pack_last(8), -1, 0, -1);
      checks++; if (cap_word.size() != 60) begin errors++; $display("FAIL aes256_count: got %0d want 60", cap_word.size()); end
      for (int j = 0; j < cap_word.size() && j < 60; j++)
         if (cap_idx[j] !== 6'(59 - j) || cap_word[j] !== mw[59 - j]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL aes256_seq: got %0d bad words want 0", bad); end
      if (cap_word.size() == 60) begin
         checks++; if (cap_word[0] !== 32'h706c631e) begin errors++; $display("FAIL aes256_first: got %h want 706c631e", cap_word[0]); end
         checks++; if (cap_word[59] !== 32'h603deb10) begin errors++; $display("FAIL aes256_last: got %h want 603deb10", cap_word[59]); end
      end
      checks++; if (valid_cycles != 60) begin errors++; $display("FAIL aes256_cycles: got %0d want 60", valid_cycles); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int k = (r % 3 == 0) ? 4 : (r % 3 == 1) ? 6 : 8;
         int n = n_of(k);
         int bad = 0;
         rand_key(k);
         run_collect(k, pack_last(k), -1, 0, -1);
         for (int j = 0; j < n; j++)
            if (j >= cap_word.size() || cap_idx[j] !== 6'(n - 1 - j) || cap_word[j] !== mw[n - 1 - j]) bad++;
         checks++; if (bad != 0 || cap_word.size() != n) begin
            errors++; $display("FAIL random_nk%0d: got %0d bad of %0d words want 0 bad of %0d", k, bad, cap_word.size(), n);
         end
         checks++; if (cap_done != 1) begin errors++; $display("FAIL random_done_nk%0d: got %0d want 1", k, cap_done); end
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      rand_key(4);
      run_collect(4, pack_last(4), 20, 3, -1);
      for (int j = 0; j < 44; j++)
         if (j >= cap_word.size() || cap_idx[j] !== 6'(43 - j) || cap_word[j] !== mw[43 - j]) bad++;
      checks++; if (bad != 0 || cap_word.size() != 44) begin errors++; $display("FAIL bp_seq: got %0d bad, %0d words want 0 bad, 44 words", bad, cap_word.size()); end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", hold_bad); end
      checks++; if (valid_cycles != 47) begin errors++; $display("FAIL bp_cycles: got %0d want 47", valid_cycles); end
   endtask

   task automatic test_async_reset();
      int cyc = 0, bad = 0;
      rand_key(4);
      sel = 4; ready_in = 1'b1;
      @(negedge clk); key_in = pack_last(4); start_in = 1'b1;
      @(negedge clk); start_in = 1'b0;
      while (cyc < 100 && !(v_valid && v_index == 6'd30)) begin
         @(negedge clk); cyc++;
      end
      checks++; if (!(v_valid && v_index == 6'd30)) begin errors++; $display("FAIL arst_reach: got index %0d want 30", v_index); end
      #1 rst = 1'b1;
      #1;
      checks++; if (v_valid !== 1'b0 || v_busy !== 1'b0) begin errors++; $display("FAIL arst_now: got valid=%b busy=%b want 0", v_valid, v_busy); end
      repeat (2) @(negedge clk);
      checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL arst_hold: got valid=%b want 0", v_valid); end
      rst = 1'b0;
      @(negedge clk);
      rand_key(4);
      run_collect(4, pack_last(4), -1, 0, -1);
      checks++; if (cap_idx.size() == 0 || cap_idx[0] !== 6'd43) begin errors++; $display("FAIL arst_restart: got %0d words want first index 43", cap_idx.size()); end
      for (int j = 0; j < 44; j++)
         if (j >= cap_word.size() || cap_word[j] !== mw[43 - j]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL arst_seq: got %0d bad want 0", bad); end
   endtask

   task automatic test_start_ignored();
      int bad = 0;
      rand_key(4);
      run_collect(4, pack_last(4), -1, 0, 10);
      for (int j = 0; j < 44; j++)
         if (j >= cap_word.size() || cap_idx[j] !== 6'(43 - j) || cap_word[j] !== mw[43 - j]) bad++;
      checks++; if (bad != 0 || cap_word.size() != 44) begin errors++; $display("FAIL restart_seq: got %0d bad, %0d words want 0 bad, 44 words", bad, cap_word.size()); end
      checks++; if (cap_done != 1) begin errors++; $display("FAIL restart_done: got %0d want 1", cap_done); end
      checks++; if (v_valid !== 1'b0) begin errors++; $display("FAIL restart_idle: got valid=%b want 0", v_valid); end
   endtask

   initial begin
      build_sbox();
      test_reset();
      test_aes128();
      test_aes192();
      test_aes256();
      test_random();
      test_backpressure();
      test_async_reset();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
